// File: rtl/t1_block_request_pkg.sv
// Shared trigger definitions: block address width, request FIFO entry layout
// {last, first, block} and the request FSM state encoding.
package t1_block_request_pkg;

   localparam int BLOCK_BITS = 9;

   typedef struct packed {
      logic                  last;
      logic                  first;
      logic [BLOCK_BITS-1:0] block;
   } req_entry_t;

   localparam int ENTRY_W = $bits(req_entry_t);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HOLD   = 2'd2
   } req_state_t;

endpackage

// File: rtl/t1_block_request_fifo.sv
// First-word-fall-through request FIFO with full/empty flags. A push while full
// is accepted only when a pop happens in the same cycle.
module t1_block_request_fifo #(
   parameter int WIDTH      = 11,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push;
   logic                  do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Head is forced to zero when empty so the outputs read 0 out of reset.
   assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/t1_block_request.sv
// Turns each T1 window into an ordered stream of block addresses with first/last
// markers. Optional per-event length limit: T1_BLOCK_REQ_MAX_LEN_EN.
module t1_block_request
   import t1_block_request_pkg::*;
#(
   parameter int BLOCK_BITS      = t1_block_request_pkg::BLOCK_BITS,
   parameter int FIFO_DEPTH_LOG2 = 4,
   parameter int MAX_BLOCKS      = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  T1_i,
   input  logic [BLOCK_BITS-1:0] T1_offset_i,
   input  logic [BLOCK_BITS-1:0] block_i,
   input  logic                  block_ce_i,
   output logic [BLOCK_BITS-1:0] req_block_o,
   output logic                  req_first_o,
   output logic                  req_last_o,
   output logic                  req_valid_o,
   input  logic                  req_ready_i,
   output logic                  overflow_o,
   output logic [15:0]           drop_count_o
);

   localparam int EW = BLOCK_BITS + 2;

   if (MAX_BLOCKS < 1) begin : g_max_blocks_invalid
      $error("MAX_BLOCKS must be at least 1");
   end

   req_state_t            state_q, state_d;
   logic                  t1_q;
   logic                  armed_q, armed_d;
   logic [BLOCK_BITS-1:0] stage_addr_q, stage_addr_d;
   logic                  stage_first_q, stage_first_d;
   logic                  overflow_q, overflow_d;
   logic [15:0]           drop_count_q, drop_count_d;

   logic                  rise;
   logic                  push;
   logic                  push_last;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  pop;
   logic                  drop;
   logic [EW-1:0]         fifo_din;
   logic [EW-1:0]         fifo_dout;

`ifdef T1_BLOCK_REQ_MAX_LEN_EN
   localparam int LEN_W = $clog2(MAX_BLOCKS) + 1;
   logic [LEN_W-1:0] len_q, len_d;
`endif

   // armed_q blocks a false rise when T1_i is already high as reset releases.
   assign rise    = T1_i && !t1_q && armed_q;
   assign armed_d = armed_q || !T1_i;

   always_comb begin
      state_d       = state_q;
      stage_addr_d  = stage_addr_q;
      stage_first_d = stage_first_q;
      push          = 1'b0;
      push_last     = 1'b0;
`ifdef T1_BLOCK_REQ_MAX_LEN_EN
      len_d         = len_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               stage_addr_d  = block_i - T1_offset_i;
               stage_first_d = 1'b1;
               state_d       = ST_ACTIVE;
`ifdef T1_BLOCK_REQ_MAX_LEN_EN
               len_d         = '0;
`endif
            end
         end
         ST_ACTIVE: begin
            // A fall coinciding with block_ce_i is handled purely as the fall.
            if (!T1_i) begin
               push      = 1'b1;
               push_last = 1'b1;
               state_d   = ST_IDLE;
            end else if (block_ce_i) begin
               push          = 1'b1;
               stage_addr_d  = stage_addr_q + 1'b1;
               stage_first_d = 1'b0;
`ifdef T1_BLOCK_REQ_MAX_LEN_EN
               len_d         = len_q + 1'b1;
               if (len_q == LEN_W'(MAX_BLOCKS - 1)) begin
                  push_last = 1'b1;
                  state_d   = ST_HOLD;
               end
`endif
            end
         end
`ifdef T1_BLOCK_REQ_MAX_LEN_EN
         ST_HOLD: begin
            if (!T1_i) begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign pop  = req_valid_o && req_ready_i;
   assign drop = push && fifo_full && !pop;

   always_comb begin
      overflow_d   = overflow_q || drop;
      drop_count_d = drop_count_q;
      if (drop && (drop_count_q != 16'hFFFF)) begin
         drop_count_d = drop_count_q + 16'd1;
      end
   end

   assign fifo_din = {push_last, stage_first_q, stage_addr_q};

   t1_block_request_fifo #(
      .WIDTH      (EW),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .din_i   (fifo_din),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign req_valid_o  = !fifo_empty;
   assign req_last_o   = fifo_dout[EW-1];
   assign req_first_o  = fifo_dout[EW-2];
   assign req_block_o  = fifo_dout[BLOCK_BITS-1:0];
   assign overflow_o   = overflow_q;
   assign drop_count_o = drop_count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         t1_q          <= 1'b0;
         armed_q       <= 1'b0;
         stage_addr_q  <= '0;
         stage_first_q <= 1'b0;
         overflow_q    <= 1'b0;
         drop_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         t1_q          <= T1_i;
         armed_q       <= armed_d;
         stage_addr_q  <= stage_addr_d;
         stage_first_q <= stage_first_d;
         overflow_q    <= overflow_d;
         drop_count_q  <= drop_count_d;
      end
   end

`ifdef T1_BLOCK_REQ_MAX_LEN_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         len_q <= '0;
      end else begin
         len_q <= len_d;
      end
   end
`endif

endmodule

// File: tb/tb_t1_block_request.sv
// Scoreboard bench for t1_block_request: expected entries are queued as events
// are driven and compared as the consumer accepts them.
module tb_t1_block_request;
   import t1_block_request_pkg::*;

   localparam int MAXB = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        t1;
   logic [8:0]  t1_offset;
   logic [8:0]  block;
   logic        block_ce;
   logic [8:0]  req_block;
   logic        req_first;
   logic        req_last;
   logic        req_valid;
   logic        req_ready;
   logic        overflow;
   logic [15:0] drop_count;

   int tests_run    = 0;
   int tests_failed = 0;

   req_entry_t sb[$];

   always #5 clk = ~clk;

   t1_block_request #(
      .BLOCK_BITS      (9),
      .FIFO_DEPTH_LOG2 (4),
      .MAX_BLOCKS      (MAXB)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .T1_i         (t1),
      .T1_offset_i  (t1_offset),
      .block_i      (block),
      .block_ce_i   (block_ce),
      .req_block_o  (req_block),
      .req_first_o  (req_first),
      .req_last_o   (req_last),
      .req_valid_o  (req_valid),
      .req_ready_i  (req_ready),
      .overflow_o   (overflow),
      .drop_count_o (drop_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Consumer side: every accepted head entry is matched against the queue.
   always @(negedge clk) begin
      if (!rst && req_valid && req_ready) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_entry", {21'd0, req_last, req_first, req_block}, 32'hFFFF_FFFF);
         end else begin
            req_entry_t e;
            e = sb.pop_front();
            check_eq("entry", {21'd0, req_last, req_first, req_block},
                     {21'd0, e.last, e.first, e.block});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one T1 window with n_ce block strobes and queues the entries the
   // design should emit, keeping at most 'keep' of them (FIFO capacity).
   task automatic run_event(input logic [8:0] blk, input logic [8:0] off,
                            input int n_ce, input bit fall_with_ce, input int keep);
      logic [8:0] start;
      int total;
      start = blk - off;
      total = fall_with_ce ? n_ce : n_ce + 1;
`ifdef T1_BLOCK_REQ_MAX_LEN_EN
      if (total > MAXB) total = MAXB;
`endif
      for (int k = 0; k < total && k < keep; k++) begin
         req_entry_t e;
         e.block = start + 9'(k);
         e.first = (k == 0);
         e.last  = (k == total - 1);
         sb.push_back(e);
      end
      t1 = 1'b1; block = blk; t1_offset = off;
      tick();
      t1_offset = 9'h1AA;
      for (int i = 0; i < n_ce; i++) begin
         tick();
         block = block + 9'd1;
         block_ce = 1'b1;
         if (fall_with_ce && i == n_ce - 1) t1 = 1'b0;
         tick();
         block_ce = 1'b0;
      end
      t1 = 1'b0;
      tick();
      tick();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check_eq({tag, "_drained"}, sb.size(), 0);
      check_eq({tag, "_valid_low"}, req_valid, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
   endtask

   initial begin
      rst = 1'b1; t1 = 1'b0; t1_offset = '0; block = '0; block_ce = 1'b0; req_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_valid", req_valid, 0);
      check_eq("rst_head", {req_last, req_first, req_block}, 0);
      check_eq("rst_overflow", overflow, 0);
      check_eq("rst_drops", drop_count, 0);
      tick();

      run_event(9'd100, 9'd8, 3, 1'b0, 64);
      drain("basic");

      run_event(9'd3, 9'd10, 2, 1'b0, 64);
      drain("wrap");

      run_event(9'd50, 9'd0, 0, 1'b0, 64);
      drain("pulse");

      run_event(9'd300, 9'd5, 3, 1'b1, 64);
      drain("fall_ce");

      req_ready = 1'b0;
      run_event(9'd400, 9'd0, 19, 1'b0, 16);
      @(negedge clk);
      check_eq("ovf_valid", req_valid, 1);
      check_eq("ovf_flag", overflow, 1);
      check_eq("ovf_drops", drop_count, 4);
      tick();
      req_ready = 1'b1;
      drain("ovf");
      check_eq("ovf_sticky", overflow, 1);

`ifdef T1_BLOCK_REQ_MAX_LEN_EN
      run_event(9'd200, 9'd0, MAXB + 8, 1'b0, 64);
      drain("maxlen");
`endif

      // Reset mid-event with T1 held high: nothing emitted, no spurious rise.
      t1 = 1'b1; block = 9'd77; t1_offset = 9'd0;
      tick();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         block_ce = 1'b1;
         tick();
         block_ce = 1'b0;
         tick();
      end
      @(negedge clk);
      check_eq("midrst_valid", req_valid, 0);
      check_eq("midrst_overflow", overflow, 0);
      check_eq("midrst_drops", drop_count, 0);
      t1 = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check_eq("midrst_after_fall", req_valid, 0);
      tick();

      run_event(9'd0, 9'd1, 1, 1'b0, 64);
      drain("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
